// File: rtl/core_rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_rvfi_pkg
// Description : Shared types for the RVFI retirement monitor: error codes,
//               counter width default and the retirement record.
// Revision    : 1.0 - initial release
// ============================================================================
package core_rvfi_pkg;

    localparam int unsigned c_errw_default = 16;
    localparam int unsigned c_xlen         = 64;
    localparam int unsigned c_ilen         = 32;

    // Lower value wins when several checks fail on one retirement.
    typedef enum logic [3:0] {
        ERR_NONE  = 4'd0,
        ERR_ORDER = 4'd1,
        ERR_PC    = 4'd2,
        ERR_X0    = 4'd3,
        ERR_RS1   = 4'd4,
        ERR_RS2   = 4'd5,
        ERR_MEM   = 4'd6,
        ERR_ALIGN = 4'd7,
        ERR_HALT  = 4'd8
    } err_code_e;

    typedef struct packed {
        logic                  valid;
        logic [63:0]           order;
        logic [c_ilen-1:0]     insn;
        logic                  trap;
        logic                  halt;
        logic                  intr;
        logic [1:0]            mode;
        logic [4:0]            rs1_addr;
        logic [4:0]            rs2_addr;
        logic [c_xlen-1:0]     rs1_rdata;
        logic [c_xlen-1:0]     rs2_rdata;
        logic [4:0]            rd_addr;
        logic [c_xlen-1:0]     rd_wdata;
        logic [c_xlen-1:0]     pc_rdata;
        logic [c_xlen-1:0]     pc_wdata;
        logic [c_xlen-1:0]     mem_addr;
        logic [c_xlen/8-1:0]   mem_rmask;
        logic [c_xlen/8-1:0]   mem_wmask;
        logic [c_xlen-1:0]     mem_rdata;
        logic [c_xlen-1:0]     mem_wdata;
    } rvfi_retire_t;

endpackage
`default_nettype wire

// File: rtl/core_rvfi_shadow_rf.sv
`default_nettype none
// ============================================================================
// Module      : core_rvfi_shadow_rf
// Description : 31-entry shadow integer register file, two async read ports,
//               one sync write port, per-entry valid bits cleared on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module core_rvfi_shadow_rf #(
    parameter int unsigned XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_valid,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_valid,
    input  logic            wr_en,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] r_regs [1:31];
    logic [31:1]     r_valid;
    logic            w_wr;

    assign w_wr = wr_en && (wr_addr != 5'd0);

    always_ff @(posedge g_clk) begin
        if (w_wr) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_valid <= '0;
        end else if (w_wr) begin
            r_valid[wr_addr] <= 1'b1;
        end
    end

    assign rs1_valid = (rs1_addr != 5'd0) && r_valid[rs1_addr];
    assign rs1_data  = (rs1_addr != 5'd0) ? r_regs[rs1_addr] : '0;
    assign rs2_valid = (rs2_addr != 5'd0) && r_valid[rs2_addr];
    assign rs2_data  = (rs2_addr != 5'd0) ? r_regs[rs2_addr] : '0;

endmodule
`default_nettype wire

// File: rtl/core_rvfi_monitor.sv
`default_nettype none
// ============================================================================
// Module      : core_rvfi_monitor
// Description : Passive RVFI retirement checker. Define RVFI_SHADOW_REGFILE_EN
//               to build the shadow register file for source-operand checks.
// Revision    : 1.0 - initial release
// ============================================================================
module core_rvfi_monitor
    import core_rvfi_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32,
    parameter int unsigned ERRW = c_errw_default
) (
    input  logic              g_clk,
    input  logic              g_reset,
    input  logic              rvfi_valid,
    input  logic [63:0]       rvfi_order,
    input  logic [ILEN-1:0]   rvfi_insn,
    input  logic              rvfi_trap,
    input  logic              rvfi_halt,
    input  logic              rvfi_intr,
    input  logic [1:0]        rvfi_mode,
    input  logic [4:0]        rvfi_rs1_addr,
    input  logic [4:0]        rvfi_rs2_addr,
    input  logic [XLEN-1:0]   rvfi_rs1_rdata,
    input  logic [XLEN-1:0]   rvfi_rs2_rdata,
    input  logic [4:0]        rvfi_rd_addr,
    input  logic [XLEN-1:0]   rvfi_rd_wdata,
    input  logic [XLEN-1:0]   rvfi_pc_rdata,
    input  logic [XLEN-1:0]   rvfi_pc_wdata,
    input  logic [XLEN-1:0]   rvfi_mem_addr,
    input  logic [XLEN/8-1:0] rvfi_mem_rmask,
    input  logic [XLEN/8-1:0] rvfi_mem_wmask,
    input  logic [XLEN-1:0]   rvfi_mem_rdata,
    input  logic [XLEN-1:0]   rvfi_mem_wdata,
    output logic              err_valid,
    output logic [3:0]        err_code,
    output logic [63:0]       err_order,
    output logic [3:0]        first_err_code,
    output logic [63:0]       first_err_order,
    output logic [ERRW-1:0]   err_count,
    output logic [63:0]       retire_count
);

    logic            r_base_seen;
    logic            r_halt_seen;
    logic            r_first_taken;
    logic [63:0]     r_exp_order;
    logic [XLEN-1:0] r_prev_pc;
    logic            r_err_valid;
    err_code_e       r_err_code;
    logic [63:0]     r_err_order;
    err_code_e       r_first_code;
    logic [63:0]     r_first_order;
    logic [ERRW-1:0] r_err_count;
    logic [63:0]     r_retire_count;

    logic            w_rs1_err;
    logic            w_rs2_err;
    logic            w_err;
    err_code_e       w_code;
    logic            w_unused;

`ifdef RVFI_SHADOW_REGFILE_EN
    logic [XLEN-1:0] w_sh_rs1_data;
    logic [XLEN-1:0] w_sh_rs2_data;
    logic            w_sh_rs1_valid;
    logic            w_sh_rs2_valid;

    // Shadow writes land on the edge, so this cycle's reads see pre-retirement state.
    core_rvfi_shadow_rf #(
        .XLEN (XLEN)
    ) u_shadow_rf (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .rs1_addr  (rvfi_rs1_addr),
        .rs1_data  (w_sh_rs1_data),
        .rs1_valid (w_sh_rs1_valid),
        .rs2_addr  (rvfi_rs2_addr),
        .rs2_data  (w_sh_rs2_data),
        .rs2_valid (w_sh_rs2_valid),
        .wr_en     (rvfi_valid && !rvfi_trap && !g_reset),
        .wr_addr   (rvfi_rd_addr),
        .wr_data   (rvfi_rd_wdata)
    );

    assign w_rs1_err = ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0)) ||
                       (w_sh_rs1_valid && (w_sh_rs1_data != rvfi_rs1_rdata));
    assign w_rs2_err = ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0)) ||
                       (w_sh_rs2_valid && (w_sh_rs2_data != rvfi_rs2_rdata));
    assign w_unused  = ^{rvfi_insn, rvfi_mode, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};
`else
    assign w_rs1_err = (rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != '0);
    assign w_rs2_err = (rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != '0);
    assign w_unused  = ^{rvfi_insn, rvfi_mode, rvfi_trap, rvfi_mem_addr, rvfi_mem_rdata,
                         rvfi_mem_wdata};
`endif

    always_comb begin
        w_code = ERR_NONE;
        if (rvfi_valid) begin
            if (r_base_seen && (rvfi_order != r_exp_order)) begin
                w_code = ERR_ORDER;
            end else if (r_base_seen && !rvfi_intr && (rvfi_pc_rdata != r_prev_pc)) begin
                w_code = ERR_PC;
            end else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0)) begin
                w_code = ERR_X0;
            end else if (w_rs1_err) begin
                w_code = ERR_RS1;
            end else if (w_rs2_err) begin
                w_code = ERR_RS2;
            end else if ((rvfi_mem_rmask != '0) && (rvfi_mem_wmask != '0)) begin
                w_code = ERR_MEM;
            end else if (rvfi_pc_wdata[0]) begin
                w_code = ERR_ALIGN;
            end else if (r_halt_seen) begin
                w_code = ERR_HALT;
            end
        end
    end

    assign w_err = (w_code != ERR_NONE);

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_base_seen    <= 1'b0;
            r_halt_seen    <= 1'b0;
            r_first_taken  <= 1'b0;
            r_exp_order    <= '0;
            r_prev_pc      <= '0;
            r_err_valid    <= 1'b0;
            r_err_code     <= ERR_NONE;
            r_err_order    <= '0;
            r_first_code   <= ERR_NONE;
            r_first_order  <= '0;
            r_err_count    <= '0;
            r_retire_count <= '0;
        end else begin
            r_err_valid <= w_err;
            if (rvfi_valid) begin
                r_base_seen    <= 1'b1;
                r_exp_order    <= rvfi_order + 64'd1;
                r_prev_pc      <= rvfi_pc_wdata;
                r_retire_count <= r_retire_count + 64'd1;
                if (rvfi_halt) begin
                    r_halt_seen <= 1'b1;
                end
            end
            if (w_err) begin
                r_err_code  <= w_code;
                r_err_order <= rvfi_order;
                if (r_err_count != {ERRW{1'b1}}) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (!r_first_taken) begin
                    r_first_taken <= 1'b1;
                    r_first_code  <= w_code;
                    r_first_order <= rvfi_order;
                end
            end
        end
    end

    assign err_valid       = r_err_valid;
    assign err_code        = r_err_code;
    assign err_order       = r_err_order;
    assign first_err_code  = r_first_code;
    assign first_err_order = r_first_order;
    assign err_count       = r_err_count;
    assign retire_count    = r_retire_count;

endmodule
`default_nettype wire

// File: doc/core_rvfi_monitor.md
# core_rvfi_monitor

Passive RVFI consumer that receives the retirement stream driven by the core's RVFI producer and checks it for protocol and architectural consistency in simulation and formal benches. It tracks retirement order, PC continuity, x0 discipline, memory-mask sanity and post-halt silence. It optionally mirrors the integer register file to cross-check source-operand read data. It drives no core logic; its outputs feed bench scoreboards and assertions.

## Interface
- XLEN, 64, data/address width
- ILEN, 32, instruction width
- ERRW, 16, width of saturating error counter
- g_clk  in  1  clock, all logic on rising edge
- g_reset  in  1  synchronous reset, active-high
- rvfi_valid  in  1  one retirement this cycle
- rvfi_order  in  64  retirement index
- rvfi_insn  in  ILEN  retired instruction
- rvfi_trap / rvfi_halt / rvfi_intr  in  1 each  trap, halt, first-of-handler flags
- rvfi_mode  in  2  privilege mode
- rvfi_rs1_addr / rvfi_rs2_addr  in  5 each  source indices
- rvfi_rs1_rdata / rvfi_rs2_rdata  in  XLEN each  source read data
- rvfi_rd_addr  in  5,  rvfi_rd_wdata  in  XLEN  destination write
- rvfi_pc_rdata / rvfi_pc_wdata  in  XLEN each  current / next PC
- rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata  in  XLEN each;  rvfi_mem_rmask, rvfi_mem_wmask  in  XLEN/8 each
- err_valid  out  1  one-cycle pulse, error detected on a retirement
- err_code  out  4  highest-priority error code for that retirement
- err_order  out  64  rvfi_order of the failing retirement
- first_err_code  out  4,  first_err_order  out  64  sticky first error
- err_count  out  ERRW  saturating count of failing retirements
- retire_count  out  64  number of retirements observed

## Operation
- Interface: one clock, `g_clk`; reset `g_reset`, synchronous and active-high.
- All checks evaluate only when rvfi_valid=1. Error codes, lowest value wins: 1 ORDER, 2 PC, 3 X0, 4 RS1, 5 RS2, 6 MEM, 7 ALIGN, 8 HALT; 0 = none.
- ORDER: the first retirement after reset sets the baseline (never fails). Each later retirement must carry the previous order+1, 64-bit wrap. The expected order always resyncs to the received order+1.
- PC: rvfi_pc_rdata must equal the previous rvfi_pc_wdata unless rvfi_intr=1. Not checked on the first retirement.
- X0: fails if rvfi_rd_addr=0 and rvfi_rd_wdata≠0.
- RS1/RS2: fails if addr=0 and rdata≠0, or addr≠0 with a valid shadow entry differing from rdata. Applies only with shadow enabled.
- MEM: fails if rmask and wmask are both nonzero.
- ALIGN: fails if rvfi_pc_wdata[0]=1.
- HALT: once any retirement with rvfi_halt=1 has been seen, every later rvfi_valid fails HALT. The halting retirement itself passes.
- Shadow update: if rd_addr≠0 and trap=0, write rd_wdata and set the valid bit. Reads in a cycle check against pre-update contents, so rs==rd in one retirement compares against the old value.
- first_err_* captures on the first err_valid after reset and holds until reset. err_count saturates at all-ones.

## Timing
- Registered outputs. err_valid, err_code and err_order appear exactly 1 cycle after the sampled retirement. Back-to-back retirements give back-to-back results with no stall.
- retire_count increments 1 cycle after each rvfi_valid.
- Reset values: every output 0; shadow valid bits 0; baseline/halt-seen flags 0.
- Reset asserted in the same cycle as rvfi_valid: the retirement is discarded, and the next retirement after reset is treated as the first.
- Simultaneous faults: a single err_valid pulse, lowest code reported, and err_count increments by 1.

## Configuration
- RVFI_SHADOW_REGFILE_EN defined: the 31×XLEN shadow register file with valid bits is built, and RS1/RS2 checks are active.
- RVFI_SHADOW_REGFILE_EN undefined: no shadow storage. RS1/RS2 codes are never raised, except the addr=0/rdata≠0 case, which stays active.

## Structure
- Shared package core_rvfi_pkg holds the error-code enum (4 bits), ERRW default, and the RVFI retirement struct typedef.
- One sub-module, core_rvfi_shadow_rf: 2 asynchronous read ports, 1 synchronous write port, per-entry valid bits with synchronous clear. It is instantiated only under RVFI_SHADOW_REGFILE_EN.

## Test plan
- Orders 5,6,7 with consistent PCs 0x1000→0x1004→0x1008 -> no err_valid; retire_count=3.
- Orders 5,7 -> err_valid 1 cycle after second, err_code=1, err_order=7; first_err_code=1.
- pc_wdata=0x2000, then next pc_rdata=0x3000, intr=0 -> code 2; repeat with intr=1 -> no error.
- Write x5=0xDEAD (trap=0), then retirement rs1=x5 rdata=0xBEEF and rd=x0 wdata=1 -> single pulse, code 3, err_count=1. Shadow build: no code-4 pulse for the same step, since code 3 wins.
- rmask=0x0F and wmask=0x0F on one retirement -> code 6. A later halt retirement passes; the next valid -> code 8.
- err_count preloaded near saturation (ERRW=2) with 5 failing retirements -> stays at 3. Reset mid-stream -> all outputs 0, and the next retirement is treated as the first.
